// File: rtl/maxnet_input_loader_pkg.sv
// Shared constants and state encoding for the Maxnet input loader.
// Frame layout: N input words followed by N*N weight words.
package maxnet_input_loader_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned N         = 4;
    localparam int unsigned FRAME_LEN = N + N * N;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStart,
        StRun
    } state_e;

endpackage

// File: rtl/maxnet_input_loader_if.sv
// Upstream word stream (valid/ready with end-of-frame marker) into the loader.
interface maxnet_input_loader_if #(
    parameter int unsigned WIDTH = maxnet_input_loader_pkg::WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/maxnet_input_loader_register.sv
// Word register with load enable and synchronous clear.
module maxnet_input_loader_register #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (ld_i) q_d = d_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/maxnet_input_loader_word_counter.sv
// Frame word counter: clear has priority over increment.
module maxnet_input_loader_word_counter #(
    parameter int unsigned Width = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (inc_i) cnt_d = cnt_q + Width'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/maxnet_input_loader.sv
// Collects one frame (inputs then weights) from a word stream, fires start, and holds
// the frame stable while the Maxnet datapath iterates.
module maxnet_input_loader #(
    parameter int unsigned WIDTH = maxnet_input_loader_pkg::WIDTH,
    parameter int unsigned N     = maxnet_input_loader_pkg::N
) (
    input  logic                   clk,
    input  logic                   rst,
    maxnet_input_loader_if.slave   in_if,
    output logic [N*WIDTH-1:0]     x_out,
    output logic [N*N*WIDTH-1:0]   w_out,
    output logic                   start,
    input  logic                   is_finished,
    output logic                   busy,
    output logic                   frame_err
);

    import maxnet_input_loader_pkg::state_e;
    import maxnet_input_loader_pkg::StIdle;
    import maxnet_input_loader_pkg::StLoad;
    import maxnet_input_loader_pkg::StStart;
    import maxnet_input_loader_pkg::StRun;

    localparam int unsigned FrameLen = N + N * N;
    localparam int unsigned CntW     = $clog2(FrameLen);
    localparam logic [CntW-1:0] LastIdx = CntW'(FrameLen - 1);

    state_e          state_d, state_q;
    logic            frame_err_d, frame_err_q;
    logic [CntW-1:0] cnt;
    logic            xfer, at_last, done, bad;

    assign in_if.in_ready = (state_q == StIdle) || (state_q == StLoad);
    assign xfer    = in_if.in_valid && in_if.in_ready;
    assign at_last = (cnt == LastIdx);
    assign done    = xfer && in_if.in_last && at_last;
    // A marker at the wrong position, or a missing marker on the final word.
    assign bad     = xfer && (in_if.in_last != at_last);

    always_comb begin
        state_d     = state_q;
        frame_err_d = frame_err_q;
        if (bad)                              frame_err_d = 1'b1;
        else if (xfer && state_q == StIdle)   frame_err_d = 1'b0;

        unique case (state_q)
            StIdle, StLoad: begin
                if (bad)       state_d = StIdle;
                else if (done) state_d = StStart;
                else if (xfer) state_d = StLoad;
            end
            StStart: state_d = StRun;
            // is_finished is only trusted from the first RUN cycle onward.
            StRun:   if (is_finished) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign start     = (state_q == StStart);
    assign busy      = (state_q == StStart) || (state_q == StRun);
    assign frame_err = frame_err_q;

    maxnet_input_loader_word_counter #(
        .Width (CntW)
    ) u_word_counter (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (done || bad),
        .inc_i (xfer && !(done || bad)),
        .cnt_o (cnt)
    );

    logic [WIDTH-1:0] word_q [FrameLen];

    for (genvar k = 0; k < FrameLen; k++) begin : g_word
        maxnet_input_loader_register #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk_i (clk),
            .rst_i (rst),
            .ld_i  (xfer && (cnt == CntW'(k))),
            .d_i   (in_if.in_data),
            .q_o   (word_q[k])
        );
        if (k < N) begin : g_x
            assign x_out[k*WIDTH +: WIDTH] = word_q[k];
        end else begin : g_w
            assign w_out[(k-N)*WIDTH +: WIDTH] = word_q[k];
        end
    end

endmodule

// File: tb/tb_maxnet_input_loader.sv
// Directed bench for maxnet_input_loader: frame table plus hand-written run/reset cases.
module tb_maxnet_input_loader;

    localparam int unsigned W  = 32;
    localparam int unsigned NN = 4;
    localparam int unsigned FL = NN + NN * NN;

    logic              clk = 1'b0;
    logic              rst;
    logic              is_finished;
    logic [NN*W-1:0]   x_out;
    logic [NN*NN*W-1:0] w_out;
    logic              start, busy, frame_err;

    always #5 clk = ~clk;

    maxnet_input_loader_if #(.WIDTH(W)) bus ();

    maxnet_input_loader #(
        .WIDTH (W),
        .N     (NN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_if       (bus),
        .x_out       (x_out),
        .w_out       (w_out),
        .start       (start),
        .is_finished (is_finished),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] exp_mem [FL];

    typedef struct {
        int base;
        int n;
        int last_pos;
        bit gaps;
        bit ok;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NN*W-1:0] model_x();
        logic [NN*W-1:0] r;
        for (int i = 0; i < int'(NN); i++) r[i*W +: W] = exp_mem[i];
        return r;
    endfunction

    function automatic logic [NN*NN*W-1:0] model_w();
        logic [NN*NN*W-1:0] r;
        for (int k = 0; k < int'(NN * NN); k++) r[k*W +: W] = exp_mem[k+NN];
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < int'(FL); i++) exp_mem[i] = '0;
    endtask

    task automatic send_words(input int base, input int n, input int last_pos, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 32'hFFFF_FFFF;
                bus.in_last  = 1'b1;
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = W'(base + i + 1);
            bus.in_last  = (i == last_pos);
            tick();
            exp_mem[i] = W'(base + i + 1);
            if (i == 0) chk("err_after_first_word", frame_err, (last_pos == 0));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_end(input string tag, input bit ok);
        chk({tag, "_start"},     start,        ok);
        chk({tag, "_busy"},      busy,         ok);
        chk({tag, "_ready"},     bus.in_ready, !ok);
        chk({tag, "_frame_err"}, frame_err,    !ok);
        chk({tag, "_x_out"},     x_out,        model_x());
        chk({tag, "_w_out"},     w_out,        model_w());
    endtask

    task automatic run_finish(input string tag);
        is_finished = 1'b0;
        tick();
        chk({tag, "_run_start"}, start,        1'b0);
        chk({tag, "_run_busy"},  busy,         1'b1);
        chk({tag, "_run_ready"}, bus.in_ready, 1'b0);
        is_finished = 1'b1;
        tick();
        chk({tag, "_idle_busy"},  busy,         1'b0);
        chk({tag, "_idle_ready"}, bus.in_ready, 1'b1);
        is_finished = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0,    20, 19, 1'b0, 1'b1};  // words 1..20 back-to-back
        vecs[1] = '{0,    20, 19, 1'b1, 1'b1};  // same frame with idle gaps
        vecs[2] = '{100,  7,  6,  1'b0, 1'b0};  // marker on word 7
        vecs[3] = '{200,  20, 19, 1'b0, 1'b1};  // recovery frame
        vecs[4] = '{300,  20, 99, 1'b0, 1'b0};  // no marker on word 20
        vecs[5] = '{400,  1,  0,  1'b0, 1'b0};  // marker on word 1
        vecs[6] = '{500,  20, 19, 1'b1, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        is_finished  = 1'b0;
        clear_model();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_start", start,        1'b0);
        chk("rst_busy",  busy,         1'b0);
        chk("rst_err",   frame_err,    1'b0);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_x",     x_out,        '0);
        chk("rst_w",     w_out,        '0);

        for (int v = 0; v < 7; v++) begin
            send_words(vecs[v].base, vecs[v].n, vecs[v].last_pos, vecs[v].gaps);
            check_end($sformatf("vec%0d", v), vecs[v].ok);
            if (v == 0) begin
                chk("vec0_x_words", x_out, 128'h00000004_00000003_00000002_00000001);
                chk("vec0_w_last",  w_out[15*W +: W], 32'd20);
            end
            if (vecs[v].ok) run_finish($sformatf("vec%0d", v));
        end

        // RUN ignores upstream traffic and holds the frame until is_finished.
        send_words(600, 20, 19, 1'b0);
        check_end("hold", 1'b1);
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_ready", bus.in_ready, 1'b0);
        end
        chk("hold_x",    x_out, model_x());
        chk("hold_w",    w_out, model_w());
        chk("hold_busy", busy,  1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        is_finished  = 1'b1;
        tick();
        is_finished  = 1'b0;
        chk("hold_exit_ready", bus.in_ready, 1'b1);
        chk("hold_exit_busy",  busy,         1'b0);
        send_words(700, 20, 19, 1'b0);
        check_end("back2back", 1'b1);
        run_finish("back2back");

        // Reset beats a simultaneous transfer and clears a sticky error.
        send_words(800, 3, 2, 1'b0);
        chk("pre_rst_err", frame_err, 1'b1);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hCAFE_0001;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        clear_model();
        chk("rst2_err",   frame_err,    1'b0);
        chk("rst2_x",     x_out,        '0);
        chk("rst2_w",     w_out,        '0);
        chk("rst2_ready", bus.in_ready, 1'b1);

        // Reset mid-LOAD discards the partial frame.
        send_words(900, 10, 99, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        chk("rst3_x",     x_out,        '0);
        chk("rst3_w",     w_out,        '0);
        chk("rst3_start", start,        1'b0);
        chk("rst3_busy",  busy,         1'b0);
        chk("rst3_ready", bus.in_ready, 1'b1);
        send_words(1000, 20, 19, 1'b0);
        check_end("after_rst", 1'b1);
        run_finish("after_rst");

        // Reset mid-RUN: no start pulse afterwards.
        send_words(1100, 20, 19, 1'b0);
        check_end("rst_run", 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        chk("rst4_busy", busy,  1'b0);
        chk("rst4_x",    x_out, '0);
        tick();
        chk("rst4_no_start", start, 1'b0);

        // is_finished already high through START must not skip RUN.
        is_finished = 1'b1;
        send_words(1200, 20, 19, 1'b0);
        check_end("fin_early", 1'b1);
        tick();
        chk("fin_early_run_busy",  busy,         1'b1);
        chk("fin_early_run_start", start,        1'b0);
        chk("fin_early_run_ready", bus.in_ready, 1'b0);
        tick();
        chk("fin_early_idle_busy",  busy,         1'b0);
        chk("fin_early_idle_ready", bus.in_ready, 1'b1);
        is_finished = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/maxnet_input_loader.md
MAXNET_INPUT_LOADER -- requirements
Module: maxnet_input_loader

Interface
REQ-001 Parameter WIDTH, default 32: bit width of every input and weight word.
REQ-002 Parameter N, default 4: neuron count; frame = N input words + N*N weight words (default 20).
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port in_valid  input  1: upstream word valid.
REQ-006 Port in_data  input  WIDTH: upstream word.
REQ-007 Port in_last  input  1: marks final word of a frame; qualified by in_valid.
REQ-008 Port in_ready  output  1: loader accepts word this cycle.
REQ-009 Port x_out  output  N*WIDTH: input vector; word i at bits [i*WIDTH +: WIDTH].
REQ-010 Port w_out  output  N*N*WIDTH: weights; word k at bits [k*WIDTH +: WIDTH], k = row*N + col; row r feeds processing unit r.
REQ-011 Port start  output  1: one-cycle pulse to the Maxnet controller; frame stable.
REQ-012 Port is_finished  input  1: level from the Maxnet datapath; iteration converged.
REQ-013 Port busy  output  1: high while a frame is being processed by Maxnet.
REQ-014 Port frame_err  output  1: sticky; in_last at wrong position.

Function
REQ-015 States: IDLE, LOAD, START, RUN.
REQ-016 Transfer occurs on a cycle with in_valid & in_ready; nothing else changes storage.
REQ-017 in_ready = 1 in IDLE and LOAD; 0 in START and RUN.
REQ-018 5-bit word counter cnt (width clog2(N+N*N)); transfer at cnt<N writes x word cnt, else w word cnt-N; cnt increments per transfer.
REQ-019 IDLE -> LOAD on first transfer (word 0 stored in that cycle).
REQ-020 Transfer with cnt = N+N*N-1 and in_last = 1 -> START; cnt cleared.
REQ-021 Transfer with in_last = 1 and cnt != last index, or cnt = last index and in_last = 0 -> frame_err set, cnt cleared, state IDLE; x_out/w_out keep partial contents; start not asserted.
REQ-022 START lasts exactly one cycle: start = 1, then -> RUN. start is combinational from state only.
REQ-023 RUN: busy = 1; x_out/w_out held constant; -> IDLE on first cycle is_finished = 1 after at least one cycle in RUN (is_finished sampled in START is ignored, as datapath still holds previous result).
REQ-024 busy = 1 in START and RUN, else 0.
REQ-025 First word of next frame is accepted in the cycle after RUN->IDLE transition; no combinational path from is_finished to in_ready.
REQ-026 frame_err cleared only by rst or by the first transfer of a new frame in IDLE.
REQ-027 Loader never modifies words; no arithmetic on data.

Reset
REQ-028 On rst: state IDLE, cnt 0, x_out 0, w_out 0, start 0, busy 0, frame_err 0, in_ready 1 in following cycle.
REQ-029 rst mid-LOAD or mid-RUN discards the frame; no start pulse follows.
REQ-030 rst has priority over any simultaneous transfer.

Structure
REQ-031 Shared package holds WIDTH, N, frame length constant, and the state encoding.
REQ-032 Storage built from the existing register sub-module (one per word, ld = transfer & address decode); one counter sub-module, word_counter, natural.
REQ-033 Loader replaces the static memory feeding the datapath; x_out/w_out connect directly to the neuron-load mux and PU weight inputs.

Verification
REQ-034 Send 20 words 1..20 back-to-back, in_last on 20 -> x_out words = 1..4, w_out words = 5..20, start pulse exactly 1 cycle after last transfer, busy high.
REQ-035 Same frame with in_valid toggled every other cycle -> identical stored contents, cnt advances only on transfers.
REQ-036 in_last on word 7 -> frame_err = 1, state IDLE, no start; next correct frame loads, frame_err clears on its first word.
REQ-037 In RUN drive in_valid = 1 for 10 cycles, hold is_finished = 0 -> in_ready = 0, x_out/w_out unchanged; raise is_finished -> IDLE next cycle, in_ready = 1.
REQ-038 rst asserted after word 10 -> all outputs 0 next cycle; full new frame then yields start.
REQ-039 is_finished held 1 throughout START -> RUN still entered; exit to IDLE one cycle later.
